// File: rtl/pulse_share_arbiter.sv
// Purpose: round-robin sharing of one fixed-length pulse output among N strobe requesters.
// Latency: a strobe into an idle block raises ext_out after the second rising edge.
// Backpressure: none; one event per requester is held pending, and repeat strobes coalesce (flagged on merged).
module pulse_share_arbiter #(
   parameter int N        = 4,
   parameter int ID_W     = 2,
   parameter int CNT_W    = 17,
   parameter int HOLD_LEN = 65536,
   parameter int GAP_LEN  = 1024
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req,
   output logic            ext_out,
   output logic [ID_W-1:0] grant_id,
   output logic            busy,
   output logic [N-1:0]    pending,
   output logic            merged
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   // Terminal counts are exact compares, so the counter never needs to wrap.
   localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_END  = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  count, count_nxt;
   logic [ID_W-1:0]   last, last_nxt;
   logic [ID_W-1:0]   grant_nxt;
   logic [ID_W-1:0]   sel;
   logic [ID_W-1:0]   idx;
   logic              found;
   logic [N-1:0]      clear;

   // Round-robin search: first pending requester starting just after the last winner.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = ID_W'((int'(last) + k) % N);
         if (!found && pending[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Next-state logic: grant from IDLE, then time the high pulse and the low guard gap.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      last_nxt  = last;
      grant_nxt = grant_id;
      clear     = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = ACTIVE;
               count_nxt = '0;
               grant_nxt = sel;
               last_nxt  = sel;
               clear     = {{(N-1){1'b0}}, 1'b1} << sel;
            end
         end
         ACTIVE: begin
            if (count == HOLD_END) begin
               count_nxt = '0;
               state_nxt = (GAP_LEN > 0) ? GAP : IDLE;
            end else begin
               count_nxt = count + CNT_W'(1);
            end
         end
         GAP: begin
            if (count == GAP_END) begin
               count_nxt = '0;
               state_nxt = IDLE;
            end else begin
               count_nxt = count + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase
   end

   // State, pending flags and registered outputs; outputs are decoded from the next state
   // so that ext_out/busy line up exactly with the ACTIVE/GAP cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         last     <= LAST_RST;
         grant_id <= '0;
         ext_out  <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         merged   <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         last     <= last_nxt;
         grant_id <= grant_nxt;
         ext_out  <= (state_nxt == ACTIVE);
         busy     <= (state_nxt != IDLE);
         // A strobe on the same edge as its grant keeps the flag set: a new event to serve.
         pending  <= req | (pending & ~clear);
         merged   <= |(req & pending);
      end
   end

endmodule

// File: tb/tb_pulse_share_arbiter.sv
// Bench for pulse_share_arbiter: fixed vectors, hand sequences for multi-cycle corners,
// and random strobes compared against a timeline-based reference model.
// Includes a second instance with no guard gap.
module tb_pulse_share_arbiter;

   localparam int HOLD = 4;
   localparam int GAPL = 2;
   localparam int IDLE_T = HOLD + GAPL;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req = '0;
   logic       ext_out, busy, merged;
   logic [1:0] grant_id;
   logic [3:0] pending;

   logic [3:0] req0 = '0;
   logic       ext0, busy0, merged0;
   logic [1:0] gid0;
   logic [3:0] pend0;

   pulse_share_arbiter #(.N(4), .ID_W(2), .CNT_W(17), .HOLD_LEN(HOLD), .GAP_LEN(GAPL)) dut (
      .clk(clk), .reset(reset), .req(req), .ext_out(ext_out), .grant_id(grant_id),
      .busy(busy), .pending(pending), .merged(merged));

   pulse_share_arbiter #(.N(4), .ID_W(2), .CNT_W(17), .HOLD_LEN(HOLD), .GAP_LEN(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .ext_out(ext0), .grant_id(gid0),
      .busy(busy0), .pending(pend0), .merged(merged0));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: m_t counts cycles since the last grant; >= IDLE_T means idle.
   int         m_t;
   logic [3:0] m_pend;
   int         m_gid, m_last;
   bit         m_merged;

   int   glog[$];
   bit   prev_ext;

   typedef struct {
      logic [3:0] r;
      bit         ext;
      bit         bsy;
      int         gid;
      logic [3:0] pnd;
      bit         mrg;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t = IDLE_T; m_pend = '0; m_gid = 0; m_last = 3; m_merged = 0;
   endtask

   task automatic model_step(input logic [3:0] r);
      logic [3:0] old, clr;
      bit         fnd;
      int         i;
      old = m_pend;
      clr = '0;
      fnd = 0;
      m_merged = |(r & old);
      if (m_t >= IDLE_T) begin
         if (old != 0) begin
            for (int k = 1; k <= 4; k++) begin
               i = (m_last + k) % 4;
               if (!fnd && old[i]) begin
                  fnd = 1; m_gid = i; m_last = i; clr[i] = 1'b1;
               end
            end
            m_t = 0;
         end
      end else begin
         m_t++;
      end
      m_pend = r | (old & ~clr);
   endtask

   task automatic check_model();
      chk("m_ext", int'(ext_out), int'(m_t < HOLD));
      chk("m_busy", int'(busy), int'(m_t < IDLE_T));
      chk("m_gid", int'(grant_id), m_gid);
      chk("m_pend", int'(pending), int'(m_pend));
      chk("m_merged", int'(merged), int'(m_merged));
   endtask

   task automatic step(input logic [3:0] r);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
      check_model();
      if (ext_out && !prev_ext) glog.push_back(int'(grant_id));
      prev_ext = ext_out;
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (!busy && pending == 0) done = 1;
         else step(4'b0000);
      end
      if (!done) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic chk_order(input string nm, input int exp[$]);
      chk({nm, "_count"}, glog.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         if (i < glog.size()) chk({nm, "_grant"}, glog[i], exp[i]);
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; req0 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ext", int'(ext_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_gid", int'(grant_id), 0);
      chk("rst_pend", int'(pending), 0);
      chk("rst_merged", int'(merged), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      prev_ext = 0;
      glog.delete();
   endtask

   initial begin
      int         e[$];
      int         g0_pat[12];
      logic [3:0] r;

      vecs[0] = '{4'b0001, 0, 0, 0, 4'b0001, 0};
      vecs[1] = '{4'b0000, 1, 1, 0, 4'b0000, 0};
      vecs[2] = '{4'b0000, 1, 1, 0, 4'b0000, 0};
      vecs[3] = '{4'b0000, 1, 1, 0, 4'b0000, 0};
      vecs[4] = '{4'b0000, 1, 1, 0, 4'b0000, 0};
      vecs[5] = '{4'b0000, 0, 1, 0, 4'b0000, 0};
      vecs[6] = '{4'b0000, 0, 1, 0, 4'b0000, 0};
      vecs[7] = '{4'b0000, 0, 0, 0, 4'b0000, 0};
      vecs[8] = '{4'b0000, 0, 0, 0, 4'b0000, 0};
      g0_pat = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};

      model_reset();
      prev_ext = 0;
      do_reset();

      // Single request from idle, table driven.
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].r);
         chk("vec_ext", int'(ext_out), int'(vecs[i].ext));
         chk("vec_busy", int'(busy), int'(vecs[i].bsy));
         chk("vec_gid", int'(grant_id), vecs[i].gid);
         chk("vec_pend", int'(pending), int'(vecs[i].pnd));
         chk("vec_merged", int'(merged), int'(vecs[i].mrg));
      end

      // Simultaneous requests from a fresh reset: 0,1,3 in order.
      do_reset();
      step(4'b1011);
      step(4'b0000);
      chk("drain1", int'(pending), 4'b1010);
      wait_idle("simul");
      e = {0, 1, 3};
      chk_order("simul", e);

      // Fairness: after 2 is served, 0 beats 2.
      glog.delete();
      step(4'b0100);
      wait_idle("fair_a");
      step(4'b0101);
      wait_idle("fair_b");
      e = {2, 0, 2};
      chk_order("fair", e);

      // Coalescing during requester 0's pulse.
      glog.delete();
      step(4'b0001);
      step(4'b0000);
      step(4'b0010);
      step(4'b0010);
      chk("merged_hit", int'(merged), 1);
      step(4'b0000);
      chk("merged_clr", int'(merged), 0);
      wait_idle("coal");
      e = {0, 1};
      chk_order("coal", e);

      // Strobe on the edge its grant clears keeps it pending.
      glog.delete();
      step(4'b0010);
      step(4'b0010);
      chk("setwins_pend", int'(pending), 4'b0010);
      wait_idle("setwins");
      e = {1, 1};
      chk_order("setwins", e);

      // Reset in the second ACTIVE cycle with requester 2 pending.
      step(4'b0001);
      step(4'b0000);
      step(4'b0100);
      chk("pre_rst_pend", int'(pending), 4'b0100);
      #2 reset = 1'b1;
      #1;
      chk("arst_ext", int'(ext_out), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_pend", int'(pending), 0);
      model_reset();
      #2 reset = 1'b0;
      prev_ext = 0;
      glog.delete();
      step(4'b0001);
      step(4'b0000);
      chk("post_rst_ext", int'(ext_out), 1);
      chk("post_rst_gid", int'(grant_id), 0);
      wait_idle("post_rst");

      // No-gap instance: two pulses separated by a single low IDLE cycle.
      for (int i = 0; i < 12; i++) begin
         req0 = (i == 0) ? 4'b0011 : 4'b0000;
         step(4'b0000);
         chk("gap0_ext", int'(ext0), g0_pat[i]);
      end
      chk("gap0_last_gid", int'(gid0), 1);

      // Random strobes against the model.
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         step(r);
      end
      wait_idle("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_share_arbiter.md
Name: pulse_share_arbiter

Overview:
- Shares one extended-pulse output (LED, buzzer or record-trigger line) between N event requesters.
- Each requester posts single-cycle strobes. The block queues one pending event per requester, grants them in round-robin order, and drives a fixed-length high pulse on the shared output, followed by a low guard gap.
- Sits between the button/event logic and the shared output driver, in place of per-source pulse stretchers.

Parameters:
- N, 4, number of requesters (2..8)
- ID_W, 2, width of grant_id; must satisfy 2^ID_W >= N
- CNT_W, 17, width of the duration counter
- HOLD_LEN, 65536, cycles ext_out stays high per grant (1..2^CNT_W-1)
- GAP_LEN, 1024, low cycles forced between consecutive pulses (0..2^CNT_W-1); 0 means no gap

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  N  per-requester event strobe, sampled every rising edge
- ext_out  out  1  shared extended pulse, registered
- grant_id  out  ID_W  index of requester owning the current/last pulse, registered
- busy  out  1  high in ACTIVE or GAP, registered
- pending  out  N  registered per-requester pending flags
- merged  out  1  registered one-cycle flag: a req hit an already-pending requester on the previous edge

Behaviour:
- Reset values: ext_out=0, grant_id=0, busy=0, pending=0, merged=0, state=IDLE, count=0, last=N-1 (so the first grant search starts at requester 0).
- Pending update each edge: pending[i] <= req[i] | (pending[i] & ~clear[i]), where clear[i] is the grant taken on that edge.
  - A req on the same edge that clears that requester's pending leaves pending[i] set (set wins).
- merged <= |(req & pending), using pending before update; a coalesced request produces no extra pulse.
- States:
  - IDLE: if |pending, select the first i with pending[i]=1, searching last+1, last+2, ... mod N. On the edge: state<=ACTIVE, count<=0, grant_id<=i, last<=i, clear[i]=1. Otherwise hold.
  - ACTIVE: count++ each edge. When count==HOLD_LEN-1: count<=0, state<=GAP if GAP_LEN>0, else IDLE.
  - GAP: count++. When count==GAP_LEN-1: count<=0, state<=IDLE.
  - Unreachable encodings go to IDLE with count=0.
- Outputs:
  - ext_out=1 exactly while state==ACTIVE, giving exactly HOLD_LEN consecutive high cycles per grant.
  - busy=1 in ACTIVE or GAP.
  - grant_id holds its value until the next grant.
- Latency: req high at edge E with block IDLE → pending at E → grant at E+1 → ext_out high after E+1. There is a 2-edge request-to-pulse latency when idle.
- Requests arriving during ACTIVE/GAP are only recorded in pending. They are served in round-robin order after return to IDLE; IDLE lasts exactly one cycle when anything is pending.
- Pending requests never time out. A requester cannot win twice in a row while another is pending.
- count is CNT_W wide and never wraps; terminal compares are exact.
- Reset mid-pulse: ext_out drops asynchronously and all pending requests are discarded.

Test Plan:
- (All with N=4, HOLD_LEN=4, GAP_LEN=2.)
- Single request: req=0001 for one cycle from idle → ext_out high exactly 4 cycles starting 2 edges later, grant_id=0, busy high for 6 cycles, then idle.
- Simultaneous requests: req=1011 in one cycle → pulses in order grant_id 0,1,3. Each pulse is 4 high cycles followed by 2 low cycles, with 1 IDLE cycle between gap and next pulse. pending drains 1011→1010→1000→0000.
- Round-robin fairness: after grant 2 completes, req=0101 together → requester 0 is served before requester 2.
- Coalescing: req[1] strobed twice during another requester's pulse → merged=1 for one cycle, only one pulse for requester 1. A req[1] on the edge its grant clears → a second pulse for 1 follows.
- Reset mid-pulse: assert reset during cycle 2 of ACTIVE with pending=0100 → ext_out, busy and pending go to 0 immediately. After release, the first request from requester 0 is granted as 0.
- GAP_LEN=0 variant: two queued requests → 8 contiguous cycles split by exactly one low IDLE cycle.
